// File: rtl/m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: operation
// encodings, the control state type and the M-extension func7 value.
package m_pkg;

    localparam logic [6:0] M_FUNC7 = 7'b0000001;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } m_state_t;

endpackage

// File: rtl/m_div_iter.sv
// One restoring-division step on magnitudes: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor and shift the
// resulting quotient bit into the low end of the dividend/quotient word.
module m_div_iter
    import m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] rem_shift;
    logic          fits;

    // The partial remainder is always below the divisor, so after the
    // shift it is below 2*divisor and the difference fits in XLEN bits.
    always_comb begin
        rem_shift = {rem_in, quo_in[XLEN-1]};
        fits      = (rem_shift >= {1'b0, divisor});
        rem_out   = fits ? (rem_shift[XLEN-1:0] - divisor) : rem_shift[XLEN-1:0];
        quo_out   = {quo_in[XLEN-2:0], fits};
    end

endmodule

// File: rtl/m_unit.sv
// Iterative RV32M multiply/divide unit sitting beside the ALU in EX.
// Multiplies and divide corner cases complete in one cycle; ordinary
// divides run a restoring divider for XLEN/DIV_BITS_PER_CYCLE cycles,
// fix the signs, then pulse done for one cycle.
module m_unit
    import m_pkg::*;
#(
    parameter int XLEN               = 32,
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m_start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [4:0]      rd_in,
    input  logic            pipeline_flush,
    output logic [XLEN-1:0] result,
    output logic [4:0]      result_rd,
    output logic            done,
    output logic            stall_req,
    output logic            busy
);

    localparam int N_ITER = XLEN / DIV_BITS_PER_CYCLE;
    localparam int CNT_W  = $clog2(N_ITER);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_ITER - 1);

    m_state_t          state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [XLEN-1:0]   quo_reg;
    logic [XLEN-1:0]   rem_reg;
    logic [XLEN-1:0]   dsr_reg;
    logic              neg_q_reg;
    logic              neg_r_reg;
    logic              sel_rem_reg;
    logic [XLEN-1:0]   result_reg;
    logic [4:0]        result_rd_reg;

    logic              accept;
    logic              is_mul;
    logic              is_signed;
    logic              is_rem;
    logic              div_by_zero;
    logic              div_ovf;
    logic              a_signed;
    logic              b_signed;
    logic [XLEN-1:0]   op1_abs;
    logic [XLEN-1:0]   op2_abs;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   quo_fixed;
    logic [XLEN-1:0]   rem_fixed;

    logic [XLEN-1:0]   rem_chain [0:DIV_BITS_PER_CYCLE];
    logic [XLEN-1:0]   quo_chain [0:DIV_BITS_PER_CYCLE];

    // Operation decode, operand conditioning and the single-cycle multiplier.
    always_comb begin
        accept      = (state_reg == ST_IDLE) & m_start & ~pipeline_flush & ~rst;
        is_mul      = ~func3[2];
        is_signed   = ~func3[0];
        is_rem      = func3[1];
        div_by_zero = (op2 == '0);
        div_ovf     = is_signed & (op1 == {1'b1, {(XLEN-1){1'b0}}}) & (op2 == '1);
        op1_abs     = (is_signed & op1[XLEN-1]) ? -op1 : op1;
        op2_abs     = (is_signed & op2[XLEN-1]) ? -op2 : op2;
        // Sign-extending both operands to 2*XLEN makes the low 2*XLEN bits of
        // the product correct for every signedness combination.
        a_signed    = (func3 != M_MULHU);
        b_signed    = (func3 == M_MUL) | (func3 == M_MULH);
        mul_a       = {{XLEN{a_signed & op1[XLEN-1]}}, op1};
        mul_b       = {{XLEN{b_signed & op2[XLEN-1]}}, op2};
        mul_prod    = mul_a * mul_b;
        quo_fixed   = neg_q_reg ? -quo_reg : quo_reg;
        rem_fixed   = neg_r_reg ? -rem_reg : rem_reg;
    end

    assign rem_chain[0] = rem_reg;
    assign quo_chain[0] = quo_reg;

    // Chain of division steps evaluated within one cycle.
    generate
        for (genvar gi = 0; gi < DIV_BITS_PER_CYCLE; gi++) begin : g_iter
            m_div_iter #(.XLEN(XLEN)) u_iter (
                .rem_in  (rem_chain[gi]),
                .quo_in  (quo_chain[gi]),
                .divisor (dsr_reg),
                .rem_out (rem_chain[gi+1]),
                .quo_out (quo_chain[gi+1])
            );
        end
    endgenerate

    // Control FSM plus all datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            quo_reg       <= '0;
            rem_reg       <= '0;
            dsr_reg       <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            sel_rem_reg   <= 1'b0;
            result_reg    <= '0;
            result_rd_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        result_rd_reg <= rd_in;
                        if (is_mul) begin
                            result_reg <= (func3 == M_MUL) ? mul_prod[XLEN-1:0]
                                                           : mul_prod[2*XLEN-1:XLEN];
                            state_reg  <= ST_DONE;
                        end else if (div_by_zero) begin
                            result_reg <= is_rem ? op1 : '1;
                            state_reg  <= ST_DONE;
                        end else if (div_ovf) begin
                            // Overflowed quotient is the dividend itself.
                            result_reg <= is_rem ? '0 : op1;
                            state_reg  <= ST_DONE;
                        end else begin
                            quo_reg     <= op1_abs;
                            rem_reg     <= '0;
                            dsr_reg     <= op2_abs;
                            neg_q_reg   <= is_signed & (op1[XLEN-1] ^ op2[XLEN-1]);
                            neg_r_reg   <= is_signed & op1[XLEN-1];
                            sel_rem_reg <= is_rem;
                            cnt_reg     <= CNT_LOAD;
                            state_reg   <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    if (pipeline_flush) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        quo_reg <= quo_chain[DIV_BITS_PER_CYCLE];
                        rem_reg <= rem_chain[DIV_BITS_PER_CYCLE];
                        if (cnt_reg == '0) begin
                            state_reg <= ST_FIX;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end
                end
                ST_FIX: begin
                    if (pipeline_flush) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        result_reg <= sel_rem_reg ? rem_fixed : quo_fixed;
                        state_reg  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The instruction still in EX is the one just finished.
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign result    = result_reg;
    assign result_rd = result_rd_reg;
    assign done      = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign stall_req = accept | (state_reg == ST_DIV) | (state_reg == ST_FIX);

endmodule

// File: tb/tb_m_unit.sv
// Directed bench for m_unit: an arithmetic reference model plus a
// cycles-remaining tracker predicts done/busy/stall_req/result every cycle.
module tb_m_unit;

    localparam int N_ITER   = 32;
    localparam int DIV_LAT  = N_ITER + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_start = 1'b0;
    logic [2:0]  func3 = 3'd0;
    logic [31:0] op1 = 32'd0;
    logic [31:0] op2 = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        pipeline_flush = 1'b0;
    logic [31:0] result;
    logic [4:0]  result_rd;
    logic        done;
    logic        stall_req;
    logic        busy;

    int total = 0;
    int bad   = 0;

    int          left = 0;
    logic [31:0] m_res = 32'd0;
    logic [4:0]  m_rd = 5'd0;
    bit          clr = 1'b0;
    bit          en = 1'b0;

    m_unit #(.XLEN(32), .DIV_BITS_PER_CYCLE(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .m_start        (m_start),
        .func3          (func3),
        .op1            (op1),
        .op2            (op2),
        .rd_in          (rd_in),
        .pipeline_flush (pipeline_flush),
        .result         (result),
        .result_rd      (result_rd),
        .done           (done),
        .stall_req      (stall_req),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // RV32M semantics computed with plain integer arithmetic.
    function automatic logic [31:0] model_calc(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        int     ia, ib;
        longint sa, sb, ua, ub, p;
        logic   ovf;
        ia  = a;
        ib  = b;
        sa  = longint'(ia);
        sb  = longint'(ib);
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return ia % ib;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Cycles from acceptance until the done cycle.
    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        if (!f3[2] || b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return DIV_LAT;
    endfunction

    // Model: left = cycles remaining through the done cycle (0 = idle).
    always @(posedge clk) begin
        if (rst) begin
            left <= 0;
            clr  <= 1'b1;
        end else begin
            clr <= 1'b0;
            if (left == 1) begin
                left <= 0;
            end else if (left > 1) begin
                left <= pipeline_flush ? 0 : left - 1;
            end else if (m_start && !pipeline_flush) begin
                left  <= model_lat(func3, op1, op2);
                m_res <= model_calc(func3, op1, op2);
                m_rd  <= rd_in;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (en) begin
            chk("done", {31'd0, done}, {31'd0, left == 1});
            chk("busy", {31'd0, busy}, {31'd0, left != 0});
            chk("stall_req", {31'd0, stall_req},
                {31'd0, (left > 1) || (left == 0 && m_start && !pipeline_flush && !rst)});
            if (left == 1) begin
                chk("result", result, m_res);
                chk("result_rd", {27'd0, result_rd}, {27'd0, m_rd});
            end
            if (clr) begin
                chk("reset_result", result, 32'd0);
                chk("reset_rd", {27'd0, result_rd}, 32'd0);
            end
        end
    end

    // Hold the instruction in EX until its done cycle, then release it.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat);
        int cyc;
        bit got;
        chk("model_pin", model_calc(f3, a, b), exp_res);
        m_start = 1'b1;
        func3   = f3;
        op1     = a;
        op2     = b;
        rd_in   = rd;
        cyc     = 0;
        got     = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                chk("latency", cyc, exp_lat);
                chk("lit_result", result, exp_res);
                chk("lit_rd", {27'd0, result_rd}, {27'd0, rd});
            end
            @(posedge clk);
            #2;
            cyc++;
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        $display("op f3=%0d a=%h b=%h rd=%0d -> result=%h cycles=%0d", f3, a, b, rd, result, cyc - 1);
        m_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #2;
        en = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        idle(1);

        // Multiply family.
        issue(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 1);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 1);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 1);
        idle(2);

        // Normal divides.
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, DIV_LAT);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, DIV_LAT);
        idle(1);
        issue(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, DIV_LAT);
        issue(3'd7, 32'd100, 32'd7, 5'd8, 32'd2, DIV_LAT);
        issue(3'd4, 32'd1000, 32'hFFFF_FFF9, 5'd9, 32'hFFFF_FF72, DIV_LAT);

        // Divide by zero and signed overflow.
        issue(3'd5, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 1);
        issue(3'd6, 32'd5, 32'd0, 5'd11, 32'd5, 1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 1);
        idle(1);

        // Flush in C10 of a divide.
        m_start = 1'b1; func3 = 3'd5; op1 = 32'd100; op2 = 32'd7; rd_in = 5'd14;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("flush_no_done", {31'd0, done}, 32'd0);
            idle(1);
        end
        pipeline_flush = 1'b1;
        idle(1);
        pipeline_flush = 1'b0;
        m_start = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_stall", {31'd0, stall_req}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        idle(1);
        issue(3'd0, 32'd3, 32'd4, 5'd15, 32'd12, 1);
        idle(1);

        // Reset in C5 of a divide.
        m_start = 1'b1; func3 = 3'd4; op1 = 32'hFFFF_FFF9; op2 = 32'd2; rd_in = 5'd16;
        idle(5);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        m_start = 1'b0;
        @(negedge clk);
        chk("rst5_result", result, 32'd0);
        chk("rst5_rd", {27'd0, result_rd}, 32'd0);
        chk("rst5_done", {31'd0, done}, 32'd0);
        chk("rst5_busy", {31'd0, busy}, 32'd0);
        chk("rst5_stall", {31'd0, stall_req}, 32'd0);
        idle(2);

        // Back-to-back: divide then multiply with no gap.
        issue(3'd5, 32'd100, 32'd7, 5'd17, 32'd14, DIV_LAT);
        issue(3'd0, 32'd3, 32'd4, 5'd18, 32'd12, 1);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
